// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin front end for a single shared combinational adder. Up to NUM_REQ
//   clients raise req with their operands. One client is granted, and its operands
//   are registered onto the adder inputs. The adder result is captured one cycle
//   later and held on a valid/ready result port, tagged with the client index.
//
// Ports
//   clk, n_rst            clock; synchronous active-low reset
//   req[NUM_REQ]          level requests, held until granted
//   req_a/req_b           packed operands, client i at [i*WIDTH +: WIDTH]
//   req_cin[NUM_REQ]      per-client carry-in
//   gnt[NUM_REQ]          one-hot grant, combinational, only while idle
//   adder_a/b/cin         registered operands to the shared adder
//   adder_sum/overflow    adder outputs
//   result_valid/ready    result handshake
//   result_id/sum/overflow captured result and owning client index
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  output logic                     adder_cin,
  input  logic [WIDTH-1:0]         adder_sum,
  input  logic                     adder_overflow,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [IDW-1:0]           result_id,
  output logic [WIDTH-1:0]         result_sum,
  output logic                     result_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   sel;
  logic             found;
  logic             load_ops;
  logic             load_res;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  // (v + k) mod NUM_REQ; NUM_REQ need not be a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] v, input int k);
    int s;
    s = (int'(v) + k) % NUM_REQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin search starting at ptr; the first set request wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[wrap_add(ptr, i)]) begin
        found = 1'b1;
        sel   = wrap_add(ptr, i);
      end
    end
  end

  always_comb begin
    sel_a   = req_a[int'(sel)*WIDTH +: WIDTH];
    sel_b   = req_b[int'(sel)*WIDTH +: WIDTH];
    sel_cin = req_cin[sel];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    gnt      = '0;
    load_ops = 1'b0;
    load_res = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt[sel] = 1'b1;
          load_ops = 1'b1;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        load_res = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (result_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result_valid = (state == DONE);

  // Operand registers keep their value while idle; ptr moves only on acceptance,
  // so the client just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ptr             <= '0;
      adder_a         <= '0;
      adder_b         <= '0;
      adder_cin       <= 1'b0;
      result_id       <= '0;
      result_sum      <= '0;
      result_overflow <= 1'b0;
    end else begin
      if (load_ops) begin
        adder_a   <= sel_a;
        adder_b   <= sel_b;
        adder_cin <= sel_cin;
        result_id <= sel;
      end
      if (load_res) begin
        result_sum      <= adder_sum;
        result_overflow <= adder_overflow;
      end
      if (accept) ptr <= wrap_add(result_id, 1);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: four clients, behavioural adder, directed and
// random operations checked against a transaction-level round-robin model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  req;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_cin;
  logic [3:0]  gnt;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic        adder_cin;
  logic [15:0] adder_sum;
  logic        adder_overflow;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_id;
  logic [15:0] result_sum;
  logic        result_overflow;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [15:0] op_a [4];
  logic [15:0] op_b [4];
  logic        op_c [4];
  logic [3:0]  reqv;
  int          m_ptr;

  always #5 clk = ~clk;

  // Stand-in for the shared 16-bit adder
  assign {adder_overflow, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};

  adder_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .gnt(gnt), .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_sum(adder_sum), .adder_overflow(adder_overflow),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_sum(result_sum), .result_overflow(result_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req = reqv;
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
      req_cin[i]        = op_c[i];
    end
  endtask

  task automatic rand_op(input int i);
    op_a[i] = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
    op_b[i] = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
    op_c[i] = 1'($urandom);
  endtask

  // Round-robin choice: first pending client at ptr, ptr+1, ... mod 4.
  function automatic int model_pick();
    for (int k = 0; k < 4; k++)
      if (reqv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // One complete operation, entered in IDLE. hold = edges in DONE with ready low;
  // late = request bits raised while the result waits.
  task automatic issue(input string tag, input bit keep, input int hold, input logic [3:0] late);
    int          g;
    logic [16:0] exp;
    logic [15:0] ea, eb;
    logic        ec;
    drive();
    #1;
    g = model_pick();
    if (g < 0) begin
      check({tag, ".idle_gnt"}, 32'(gnt), 32'd0);
      tick();
      return;
    end
    check({tag, ".gnt"}, 32'(gnt), 32'(4'b0001 << g));
    ea  = op_a[g];
    eb  = op_b[g];
    ec  = op_c[g];
    exp = 17'(ea) + 17'(eb) + 17'(ec);
    tick();
    if (keep) rand_op(g);
    else      reqv[g] = 1'b0;
    drive();
    if (hold > 0) result_ready = 1'b0;
    #1;
    check({tag, ".cmp_gnt"}, 32'(gnt), 32'd0);
    check({tag, ".cmp_valid"}, 32'(result_valid), 32'd0);
    check({tag, ".adder_a"}, 32'(adder_a), 32'(ea));
    check({tag, ".adder_b"}, 32'(adder_b), 32'(eb));
    check({tag, ".adder_cin"}, 32'(adder_cin), 32'(ec));
    tick();
    check({tag, ".valid"}, 32'(result_valid), 32'd1);
    check({tag, ".id"}, 32'(result_id), 32'(g));
    check({tag, ".sum"}, 32'(result_sum), 32'(exp[15:0]));
    check({tag, ".ovf"}, 32'(result_overflow), 32'(exp[16]));
    reqv = reqv | late;
    drive();
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(result_valid), 32'd1);
      check({tag, ".hold_gnt"}, 32'(gnt), 32'd0);
      check({tag, ".hold_sum"}, 32'(result_sum), 32'(exp[15:0]));
      check({tag, ".hold_id"}, 32'(result_id), 32'(g));
      check({tag, ".hold_a"}, 32'(adder_a), 32'(ea));
    end
    result_ready = 1'b1;
    tick();
    check({tag, ".accepted"}, 32'(result_valid), 32'd0);
    m_ptr = (g + 1) % 4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] newbits;
    n_rst        = 1'b0;
    result_ready = 1'b1;
    reqv         = '0;
    m_ptr        = 0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = 1'b0;
    end
    drive();
    tick();
    tick();
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.valid", 32'(result_valid), 32'd0);
    check("rst.adder_a", 32'(adder_a), 32'd0);
    check("rst.adder_b", 32'(adder_b), 32'd0);
    check("rst.adder_cin", 32'(adder_cin), 32'd0);
    check("rst.id", 32'(result_id), 32'd0);
    check("rst.sum", 32'(result_sum), 32'd0);
    check("rst.ovf", 32'(result_overflow), 32'd0);
    n_rst = 1'b1;

    // All four requesting continuously: order 0,1,2,3,0
    reqv = 4'b1111;
    for (int i = 0; i < 4; i++) rand_op(i);
    for (int i = 0; i < 5; i++) issue("rr_all", 1'b1, 0, 4'b0000);
    reqv = '0;
    drive();
    #1;
    check("idle.gnt", 32'(gnt), 32'd0);
    tick();
    check("idle.valid", 32'(result_valid), 32'd0);

    // Single request, simple sum
    op_a[0] = 16'h1111; op_b[0] = 16'h0001; op_c[0] = 1'b0;
    reqv = 4'b0001;
    issue("basic", 1'b0, 0, 4'b0000);

    // Back-pressure: client 0 waits 5 edges, client 1 arrives meanwhile
    rand_op(0);
    rand_op(1);
    reqv = 4'b0001;
    issue("stall", 1'b0, 5, 4'b0010);
    issue("after_stall", 1'b0, 0, 4'b0000);

    // Full carry chain with carry-in
    op_a[2] = 16'hFFFF; op_b[2] = 16'h0001; op_c[2] = 1'b1;
    reqv = 4'b0100;
    issue("overflow", 1'b0, 0, 4'b0000);

    // ptr is 3: requests 0 and 1 must wrap to 0 first
    rand_op(0);
    rand_op(1);
    reqv = 4'b0011;
    issue("wrap0", 1'b0, 0, 4'b0000);
    issue("wrap1", 1'b0, 0, 4'b0000);

    // Reset during COMPUTE discards the operation and clears ptr
    op_a[0] = 16'h1111; op_b[0] = 16'h1111; op_c[0] = 1'b0;
    reqv = 4'b0001;
    drive();
    #1;
    check("mid_rst.gnt", 32'(gnt), 32'd1);
    tick();
    reqv = '0;
    drive();
    n_rst = 1'b0;
    tick();
    check("mid_rst.valid", 32'(result_valid), 32'd0);
    check("mid_rst.gnt", 32'(gnt), 32'd0);
    check("mid_rst.sum", 32'(result_sum), 32'd0);
    check("mid_rst.adder_a", 32'(adder_a), 32'd0);
    n_rst = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst.no_result", 32'(result_valid), 32'd0);
      check("mid_rst.sum_clear", 32'(result_sum), 32'd0);
    end
    reqv = 4'b1111;
    for (int i = 0; i < 4; i++) rand_op(i);
    issue("post_rst", 1'b0, 0, 4'b0000);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      newbits = 4'($urandom) & ~reqv;
      for (int i = 0; i < 4; i++) if (newbits[i]) rand_op(i);
      reqv = reqv | newbits;
      issue("rnd", 1'($urandom), int'($urandom_range(2)), 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
